// File: rtl/pcie_tx_pkg.sv
// Purpose: shared symbol constants, encodings and types for the TX ordered-set path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pcie_tx_pkg;

    // 8b/10b control and data symbols used by the ordered sets
    localparam logic [7:0] SYM_COM  = 8'hBC;
    localparam logic [7:0] SYM_SKP  = 8'h1C;
    localparam logic [7:0] SYM_TS1  = 8'h4A;
    localparam logic [7:0] SYM_TS2  = 8'h45;
    localparam logic [7:0] SYM_RATE = 8'h02;
    localparam logic [7:0] SYM_PAD0 = 8'h00;

    // data_len encodings (2'b11 is illegal but forwarded untouched)
    localparam logic [1:0] LEN_1 = 2'b00;
    localparam logic [1:0] LEN_2 = 2'b01;
    localparam logic [1:0] LEN_4 = 2'b10;

    // Wide enough for the largest legal SKP interval (4095)
    localparam int CNT_W = 12;

    typedef enum logic [1:0] {
        TS_NONE = 2'b00,
        TS_REQ1 = 2'b01,
        TS_REQ2 = 2'b10,
        TS_RSVD = 2'b11
    } ts_req_e;

    typedef enum logic {
        S_DATA = 1'b0,
        S_TS   = 1'b1
    } state_e;

    // One output beat towards the scrambler
    typedef struct packed {
        logic [31:0] dat;
        logic [3:0]  datak;
        logic [3:0]  train;
        logic [1:0]  len;
    } tx_word_t;

    function automatic logic [7:0] ts_id(input logic is_ts2);
        return is_ts2 ? SYM_TS2 : SYM_TS1;
    endfunction

endpackage

// File: rtl/skp_timer.sv
// Purpose: free-running SKP interval counter with a sticky pending flag.
// Latency: pending rises SKP_INTERVAL-1 cycles after reset/clear, so one SKP per SKP_INTERVAL cycles.
// Backpressure: pending is held (counter frozen) until the consumer pulses clr_i.
module skp_timer
    import pcie_tx_pkg::*;
#(
    parameter int unsigned SKP_INTERVAL = 295
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic pending_o
);

    // Pending becomes visible in the same cycle the count reaches SKP_INTERVAL-1,
    // which makes the SKP cycle itself the last slot of the interval.
    localparam logic [CNT_W-1:0] SET_AT = CNT_W'(SKP_INTERVAL - 2);

    logic [CNT_W-1:0] cnt_q;

    // Count while idle, freeze once pending, restart on the SKP emission
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            pending_o <= 1'b0;
        end else if (clr_i) begin
            cnt_q     <= '0;
            pending_o <= 1'b0;
        end else if (!pending_o) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == SET_AT) begin
                pending_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_os_inserter.sv
// Purpose: mux TLP words, SKP and TS1/TS2 ordered sets into the scrambler word stream.
// Latency: one cycle from decision to registered output; valid_o is high every cycle after reset.
// Backpressure: tlp_ready_o drops while an ordered set is pending or in progress; no backpressure from downstream.
module tx_os_inserter
    import pcie_tx_pkg::*;
#(
    parameter int unsigned SKP_INTERVAL = 295
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        tlp_valid_i,
    output logic        tlp_ready_o,
    input  logic [31:0] tlp_data_i,
    input  logic [1:0]  tlp_len_i,
    input  logic [1:0]  ts_req_i,
    input  logic [7:0]  link_num_i,
    input  logic [4:0]  lane_num_i,
    input  logic [7:0]  n_fts_i,
    output logic [31:0] indata_o,
    output logic [3:0]  datak_o,
    output logic [3:0]  training_sequence_o,
    output logic [1:0]  data_len_o,
    output logic        valid_o,
    output logic        os_busy_o
);

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic       ts2_q, ts2_d;
    logic [7:0] link_q, link_d;
    logic [4:0] lane_q, lane_d;
    logic [7:0] nfts_q, nfts_d;

    logic       skp_pending;
    logic       skp_clr;
    logic       ts_req_vld;
    logic [7:0] id_q;

    tx_word_t   word_d, word_q;
    logic       busy_d, busy_q, valid_q;

    assign ts_req_vld  = (ts_req_i == TS_REQ1) || (ts_req_i == TS_REQ2);
    assign id_q        = ts_id(ts2_q);
    assign tlp_ready_o = (state_q == S_DATA) && !skp_pending && !ts_req_vld;

    skp_timer #(
        .SKP_INTERVAL (SKP_INTERVAL)
    ) u_skp_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (skp_clr),
        .pending_o (skp_pending)
    );

    // State register plus the TS fields latched when a set starts
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_DATA;
            idx_q   <= 2'd0;
            ts2_q   <= 1'b0;
            link_q  <= 8'h00;
            lane_q  <= 5'h00;
            nfts_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ts2_q   <= ts2_d;
            link_q  <= link_d;
            lane_q  <= lane_d;
            nfts_q  <= nfts_d;
        end
    end

    // Next state: a TS request only starts a set when no SKP is waiting; a running set ignores ts_req_i
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ts2_d   = ts2_q;
        link_d  = link_q;
        lane_d  = lane_q;
        nfts_d  = nfts_q;
        case (state_q)
            S_DATA: begin
                if (!skp_pending && ts_req_vld) begin
                    state_d = S_TS;
                    idx_d   = 2'd1;
                    ts2_d   = (ts_req_i == TS_REQ2);
                    link_d  = link_num_i;
                    lane_d  = lane_num_i;
                    nfts_d  = n_fts_i;
                end
            end
            S_TS: begin
                if (idx_q == 2'd3) begin
                    state_d = S_DATA;
                    idx_d   = 2'd0;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            default: begin
                state_d = S_DATA;
                idx_d   = 2'd0;
            end
        endcase
    end

    // Output decode: pick the next word by priority SKP > TS word 0 > TLP > idle
    always_comb begin
        word_d  = '{dat: 32'h0, datak: 4'b0000, train: 4'b0000, len: LEN_4};
        busy_d  = 1'b0;
        skp_clr = 1'b0;
        case (state_q)
            S_DATA: begin
                if (skp_pending) begin
                    word_d  = '{dat: {SYM_SKP, SYM_SKP, SYM_SKP, SYM_COM},
                                datak: 4'b1111, train: 4'b1111, len: LEN_4};
                    skp_clr = 1'b1;
                end else if (ts_req_vld) begin
                    word_d = '{dat: {n_fts_i, 3'b000, lane_num_i, link_num_i, SYM_COM},
                               datak: 4'b0001, train: 4'b1111, len: LEN_4};
                    busy_d = 1'b1;
                end else if (tlp_valid_i) begin
                    word_d = '{dat: tlp_data_i, datak: 4'b0000, train: 4'b0000, len: tlp_len_i};
                end
            end
            S_TS: begin
                busy_d = 1'b1;
                if (idx_q == 2'd1) begin
                    word_d = '{dat: {id_q, id_q, SYM_PAD0, SYM_RATE},
                               datak: 4'b0000, train: 4'b1111, len: LEN_4};
                end else begin
                    word_d = '{dat: {id_q, id_q, id_q, id_q},
                               datak: 4'b0000, train: 4'b1111, len: LEN_4};
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Registered outputs towards the scrambler
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            word_q  <= '{dat: 32'h0, datak: 4'b0000, train: 4'b0000, len: LEN_4};
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            busy_q  <= busy_d;
            valid_q <= 1'b1;
        end
    end

    assign indata_o            = word_q.dat;
    assign datak_o             = word_q.datak;
    assign training_sequence_o = word_q.train;
    assign data_len_o          = word_q.len;
    assign valid_o             = valid_q;
    assign os_busy_o           = busy_q;

endmodule

// File: tb/tb_tx_os_inserter.sv
// Purpose: self-checking bench for tx_os_inserter against a word-queue reference model.
// Latency: expects each decision to appear on the outputs one clock later.
// Backpressure: checks tlp_ready_o in every decision cycle.
module tb_tx_os_inserter;

    localparam int INTV = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tlp_valid;
    logic        tlp_ready;
    logic [31:0] tlp_data;
    logic [1:0]  tlp_len;
    logic [1:0]  ts_req;
    logic [7:0]  link_num;
    logic [4:0]  lane_num;
    logic [7:0]  n_fts;
    logic [31:0] indata;
    logic [3:0]  datak;
    logic [3:0]  train;
    logic [1:0]  data_len;
    logic        valid;
    logic        os_busy;

    int checks = 0;
    int errors = 0;

    // Reference model: cycles since the last SKP (saturating) and the TS words still owed
    int          since_skp = 0;
    logic [31:0] q_dat[$];
    logic [3:0]  q_k[$];

    logic [31:0] e_dat;
    logic [3:0]  e_k, e_tr;
    logic [1:0]  e_len;
    logic        e_busy;

    always #5 clk = ~clk;

    tx_os_inserter #(
        .SKP_INTERVAL (INTV)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .tlp_valid_i         (tlp_valid),
        .tlp_ready_o         (tlp_ready),
        .tlp_data_i          (tlp_data),
        .tlp_len_i           (tlp_len),
        .ts_req_i            (ts_req),
        .link_num_i          (link_num),
        .lane_num_i          (lane_num),
        .n_fts_i             (n_fts),
        .indata_o            (indata),
        .datak_o             (datak),
        .training_sequence_o (train),
        .data_len_o          (data_len),
        .valid_o             (valid),
        .os_busy_o           (os_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Hold reset across one rising edge and check the reset values
    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        tlp_valid = 1'($urandom_range(0, 1));
        tlp_data  = $urandom;
        ts_req    = 2'($urandom_range(0, 3));
        @(posedge clk);
        #1;
        chk("rst_indata", indata, 32'h0);
        chk("rst_datak", 32'(datak), 32'h0);
        chk("rst_train", 32'(train), 32'h0);
        chk("rst_len", 32'(data_len), 32'h2);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_busy", 32'(os_busy), 32'h0);
        since_skp = 0;
        q_dat.delete();
        q_k.delete();
    endtask

    // One decision cycle: drive, check ready, predict, then check the registered word
    task automatic step(input logic v, input logic [31:0] d, input logic [1:0] l,
                        input logic [1:0] tr, input logic [7:0] lk, input logic [4:0] ln,
                        input logic [7:0] nf);
        logic       due, trv, exp_rdy, skp;
        logic [7:0] id;
        @(negedge clk);
        rst_n     = 1'b1;
        tlp_valid = v;
        tlp_data  = d;
        tlp_len   = l;
        ts_req    = tr;
        link_num  = lk;
        lane_num  = ln;
        n_fts     = nf;
        #1;
        due     = (since_skp == INTV - 1);
        trv     = (tr == 2'd1) || (tr == 2'd2);
        exp_rdy = (q_dat.size() == 0) && !due && !trv;
        chk("ready", 32'(tlp_ready), 32'(exp_rdy));
        skp    = 1'b0;
        e_busy = 1'b0;
        if (q_dat.size() != 0) begin
            e_dat  = q_dat.pop_front();
            e_k    = q_k.pop_front();
            e_tr   = 4'hF;
            e_len  = 2'd2;
            e_busy = 1'b1;
        end else if (due) begin
            e_dat = 32'h1C1C1CBC;
            e_k   = 4'hF;
            e_tr  = 4'hF;
            e_len = 2'd2;
            skp   = 1'b1;
        end else if (trv) begin
            id     = (tr == 2'd1) ? 8'h4A : 8'h45;
            e_dat  = {nf, 3'b000, ln, lk, 8'hBC};
            e_k    = 4'h1;
            e_tr   = 4'hF;
            e_len  = 2'd2;
            e_busy = 1'b1;
            q_dat.push_back({id, id, 8'h00, 8'h02});
            q_k.push_back(4'h0);
            q_dat.push_back({id, id, id, id});
            q_k.push_back(4'h0);
            q_dat.push_back({id, id, id, id});
            q_k.push_back(4'h0);
        end else if (v) begin
            e_dat = d;
            e_k   = 4'h0;
            e_tr  = 4'h0;
            e_len = l;
        end else begin
            e_dat = 32'h0;
            e_k   = 4'h0;
            e_tr  = 4'h0;
            e_len = 2'd2;
        end
        if (skp) since_skp = 0;
        else if (since_skp < INTV - 1) since_skp++;
        @(posedge clk);
        #1;
        chk("indata", indata, e_dat);
        chk("datak", 32'(datak), 32'(e_k));
        chk("train", 32'(train), 32'(e_tr));
        chk("len", 32'(data_len), 32'(e_len));
        chk("valid", 32'(valid), 32'h1);
        chk("busy", 32'(os_busy), 32'(e_busy));
    endtask

    task automatic idle_step();
        step(1'b0, 32'h0, 2'd2, 2'd0, 8'h00, 5'h00, 8'h00);
    endtask

    initial begin
        int skp_seen;
        rst_n     = 1'b0;
        tlp_valid = 1'b0;
        tlp_data  = 32'h0;
        tlp_len   = 2'd2;
        ts_req    = 2'd0;
        link_num  = 8'h00;
        lane_num  = 5'h00;
        n_fts     = 8'h00;

        // Reset then a single 4-byte TLP word
        do_reset();
        step(1'b1, 32'hA1B2C3D4, 2'd2, 2'd0, 8'h00, 5'h00, 8'h00);
        chk("tlp_word", indata, 32'hA1B2C3D4);

        // TS1 with link 5, lane 3, n_fts 0x20; ts_req changes mid-set are ignored
        step(1'b1, 32'h11111111, 2'd2, 2'd1, 8'h05, 5'd3, 8'h20);
        chk("ts1_w0", indata, 32'h200305BC);
        chk("ts1_w0_k", 32'(datak), 32'h1);
        step(1'b1, 32'h22222222, 2'd2, 2'd2, 8'h77, 5'd9, 8'h99);
        chk("ts1_w1", indata, 32'h4A4A0002);
        step(1'b1, 32'h33333333, 2'd2, 2'd2, 8'h77, 5'd9, 8'h99);
        chk("ts1_w2", indata, 32'h4A4A4A4A);
        step(1'b1, 32'h44444444, 2'd1, 2'd0, 8'h00, 5'd0, 8'h00);
        chk("ts1_w3", indata, 32'h4A4A4A4A);

        // Idle link: one SKP every INTV cycles
        do_reset();
        skp_seen = 0;
        for (int i = 0; i < 3 * INTV; i++) begin
            idle_step();
            if (indata === 32'h1C1C1CBC) skp_seen++;
        end
        chk("skp_count", 32'(skp_seen), 32'd3);

        // TS2 started just before the SKP becomes due: set stays intact, SKP follows
        do_reset();
        for (int i = 0; i < INTV - 2; i++) idle_step();
        step(1'b0, 32'h0, 2'd2, 2'd2, 8'h0A, 5'd1, 8'h10);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 2'd2, 2'd1, 8'h00, 5'd0, 8'h00);
        chk("ts2_last", indata, 32'h45454545);
        idle_step();
        chk("skp_after_ts", indata, 32'h1C1C1CBC);
        for (int i = 0; i < INTV - 1; i++) idle_step();
        idle_step();
        chk("skp_restart", indata, 32'h1C1C1CBC);

        // SKP and TS2 requested together: SKP first, TS2 word 0 next
        do_reset();
        for (int i = 0; i < INTV - 1; i++) idle_step();
        step(1'b1, 32'h5555AAAA, 2'd2, 2'd2, 8'h11, 5'h1F, 8'h80);
        chk("skp_first", indata, 32'h1C1C1CBC);
        step(1'b1, 32'h5555AAAA, 2'd2, 2'd2, 8'h11, 5'h1F, 8'h80);
        chk("ts2_w0", indata, 32'h801F11BC);
        chk("ts2_w0_busy", 32'(os_busy), 32'h1);
        for (int i = 0; i < 3; i++) idle_step();

        // Reset during a TS1 set aborts it; next word is idle
        do_reset();
        step(1'b0, 32'h0, 2'd2, 2'd1, 8'h01, 5'd2, 8'h03);
        step(1'b0, 32'h0, 2'd2, 2'd0, 8'h00, 5'd0, 8'h00);
        do_reset();
        idle_step();
        chk("post_rst_idle", indata, 32'h0);
        chk("post_rst_busy", 32'(os_busy), 32'h0);

        // Randomised traffic with occasional TS requests, illegal lengths and resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 3) != 0), $urandom, 2'($urandom_range(0, 3)),
                     ($urandom_range(0, 9) < 2) ? 2'($urandom_range(1, 3)) : 2'd0,
                     8'($urandom), 5'($urandom), 8'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_os_inserter.md
TX_OS_INSERTER -- requirements
Module: tx_os_inserter

Interface
REQ-001 SKP_INTERVAL, 295, number of cycles between SKP ordered-set requests; legal range 8..4095.
REQ-002 clk_i  in  1  single clock, rising edge.
REQ-003 rst_ni  in  1  reset, synchronous, active-low.
REQ-004 tlp_valid_i  in  1  upstream word available.
REQ-005 tlp_ready_o  out  1  word accepted this cycle when high together with tlp_valid_i.
REQ-006 tlp_data_i  in  32  upstream bytes; byte 0 in [7:0].
REQ-007 tlp_len_i  in  2  valid bytes: 00=1, 01=2, 10=4, 11 illegal.
REQ-008 ts_req_i  in  2  00 none, 01 TS1, 10 TS2, 11 treated as none.
REQ-009 link_num_i / lane_num_i / n_fts_i  in  8/5/8  TS symbol 1, 2 and 3 contents.
REQ-010 indata_o  out  32  word to scrambler.
REQ-011 datak_o  out  4  per-byte K flag.
REQ-012 training_sequence_o  out  4  per-byte scramble-bypass flag.
REQ-013 data_len_o  out  2  same encoding as tlp_len_i.
REQ-014 valid_o  out  1  output word valid.
REQ-015 os_busy_o  out  1  high while a TS ordered set is in progress.

Function
REQ-016 All outputs SHALL be registered, with a latency of one cycle from the decision cycle to the output.
REQ-017 FSM states: S_DATA, S_TS; word index 0..3 in S_TS.
REQ-018 Decision in S_DATA, in priority order: skp_pending -> SKP word; ts_req 01/10 -> TS word 0, latch type, link, lane and n_fts, go to S_TS with index 1; tlp_valid_i -> TLP word; else -> idle word.
REQ-019 S_TS emits words 1, 2 and 3 on consecutive cycles; after word 3 it returns to S_DATA; ts_req_i changes mid-set SHALL be ignored.
REQ-020 tlp_ready_o = (state==S_DATA) & ~skp_pending & (ts_req_i not 01/10); combinational.
REQ-021 TS word 0 = {n_fts, 3'b0+lane, link, 8'hBC}, datak 0001; word 1 = {ID, ID, 8'h00, 8'h02}; words 2-3 = {ID x4}; ID = 8'h4A for TS1 and 8'h45 for TS2; datak 0000 for words 1-3; training_sequence 1111 and data_len 10 for all TS words.
REQ-022 SKP word = {8'h1C, 8'h1C, 8'h1C, 8'hBC}, datak 1111, training_sequence 1111, data_len 10.
REQ-023 TLP word = tlp_data_i unmodified, datak 0000, training_sequence 0000, data_len = tlp_len_i.
REQ-024 Idle word = 32'h0, datak 0000, training_sequence 0000, data_len 10.
REQ-025 valid_o SHALL be 1 every cycle after reset, because the scrambler has no backpressure.
REQ-026 SKP counter: increments each cycle while ~skp_pending; skp_pending is set when count==SKP_INTERVAL-1; on SKP emission the counter clears to 0 and skp_pending clears.
REQ-027 A skp_pending that arises during S_TS SHALL be held, and the SKP word SHALL be emitted in the cycle after TS word 3; the TS set is never split.
REQ-028 When skp_pending and ts_req are asserted simultaneously, SKP SHALL be emitted first, followed by TS word 0 in the next cycle.
REQ-029 A tlp_len_i of 11 SHALL be forwarded unchanged; checking it is the scrambler's responsibility.
REQ-030 os_busy_o SHALL be high in the cycles that output TS words 0-3.

Reset
REQ-031 rst_ni low at a clock edge SHALL force: state S_DATA, index 0, counter 0, skp_pending 0, indata_o 0, datak_o 0, training_sequence_o 0, data_len_o 10, valid_o 0, os_busy_o 0.
REQ-032 A reset during S_TS SHALL abort the set, and the first post-reset output SHALL be a decision-cycle word.

Structure
REQ-033 Package pcie_tx_pkg SHALL hold the symbol constants (COM BC, SKP 1C, TS1 4A, TS2 45, RATE 02), the data_len encodings, the ts_req encodings and the FSM state encoding.
REQ-034 The SKP counter and pending flag SHALL be one sub-module, skp_timer (SKP_INTERVAL, clk_i, rst_ni, clr_i, pending_o).

Verification
REQ-035 Reset, then tlp_valid=1, data 32'hA1B2C3D4, len 10 -> next cycle indata_o=A1B2C3D4, datak 0000, train 0000, len 10, ready=1.
REQ-036 ts_req=01, link 8'h05, lane 3, n_fts 8'h20 -> 4 words: 2003_05BC/0001, 4A4A_0002, 4A4A4A4A, 4A4A4A4A; train 1111; ready=0 for 4 cycles.
REQ-037 SKP_INTERVAL=8, idle -> an SKP word 1C1C1CBC/1111 appears every 8 cycles, with idle words between.
REQ-038 SKP_INTERVAL=8, TS2 started at count 6 -> all 4 TS2 words are emitted intact, then SKP, then the interval restarts.
REQ-039 ts_req=10 and skp_pending in the same cycle -> SKP word, then TS2 word 0 next cycle.
REQ-040 rst_ni=0 during TS1 word 2 -> outputs take reset values next cycle; with no requests the following word is idle.
